prefetch_queue: RTL and testbench

Instruction-byte prefetcher sitting directly upstream of the core's opcode/ModRM decoder. It fetches code bytes from the 8-bit memory bus at CS:IP while the bus is idle, buffers them in a small FIFO, and hands them to the decoder one per cycle. A flush reloads CS:IP on control transfers or segment loads.

---
 rtl/core_pkg.sv | 21 ++
 rtl/prefetch_ram.sv | 29 ++
 rtl/prefetch_queue.sv | 139 +++++++++++++
 tb/tb_prefetch_queue.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg -- shared constants for the instruction prefetch path.
//   DEPTH_DEF        default prefetch queue capacity in bytes
//   RESET_CS_DEF     code segment loaded by reset
//   RESET_IP_DEF     instruction pointer loaded by reset
//   clog2()          width helper for pointers and counters
package core_pkg;

  localparam int          DEPTH_DEF    = 6;
  localparam logic [15:0] RESET_CS_DEF = 16'hFFFF;
  localparam logic [15:0] RESET_IP_DEF = 16'h0000;

  // Smallest r with 2**r >= n; returns at least 1 so a 2-entry
  // queue still gets a one-bit pointer.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/prefetch_ram.sv
// prefetch_ram -- DEPTH x 8 register file backing the prefetch queue.
// Ports:
//   clock    in   system clock
//   wr_en    in   write strobe
//   wr_addr  in   write slot (PW bits, always < DEPTH)
//   wr_data  in   byte to store
//   rd_addr  in   read slot (PW bits, always < DEPTH)
//   rd_data  out  byte at rd_addr (asynchronous read)
module prefetch_ram #(
  parameter int DEPTH = 6,
  parameter int PW    = 3
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [PW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [PW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/prefetch_queue.sv
// prefetch_queue -- instruction-byte prefetcher feeding the decoder.
// Fetches code bytes at CS:IP whenever the bus is granted and space is
// available, buffers them in a DEPTH-byte FIFO and presents the head byte.
// Ports:
//   clock, resetn            clock and synchronous active-low reset
//   bus_grant                prefetcher may use the bus this cycle
//   mem_addr, mem_req        fetch address ({cs,4'h0}+fetch_ip) and strobe
//   mem_data                 read data, valid the cycle after mem_req
//   q_data, q_valid, q_ip    head byte, its valid flag and its IP
//   q_pop                    decoder consumes the head byte
//   flush, flush_cs/ip       discard everything and restart at new CS:IP
// Build option: define PREFETCH_BYPASS_EN to forward a captured byte
// straight to q_data when the queue is empty (one cycle less latency).
module prefetch_queue
  import core_pkg::*;
#(
  parameter int          DEPTH    = DEPTH_DEF,
  parameter logic [15:0] RESET_CS = RESET_CS_DEF,
  parameter logic [15:0] RESET_IP = RESET_IP_DEF
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        bus_grant,
  output logic [19:0] mem_addr,
  output logic        mem_req,
  input  logic [7:0]  mem_data,
  output logic [7:0]  q_data,
  output logic        q_valid,
  input  logic        q_pop,
  output logic [15:0] q_ip,
  input  logic        flush,
  input  logic [15:0] flush_cs,
  input  logic [15:0] flush_ip
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic          pend_q, pend_d;
  logic [15:0]   cs_q, cs_d, fetch_ip_q, fetch_ip_d, head_ip_q, head_ip_d;

  logic [CW:0]   occupancy;
  logic          issue, capture, stored, bypass_hit, pop, pop_stored, wr_en;
  logic [7:0]    rd_data;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // The in-flight byte already owns a slot, so a capture can never overflow.
  assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, pend_q};
  assign issue     = bus_grant & ~flush & (occupancy < (CW+1)'(DEPTH));
  assign capture   = pend_q & ~flush;
  assign stored    = (count_q != '0);

  assign mem_req   = issue;
  assign mem_addr  = {cs_q, 4'h0} + {4'h0, fetch_ip_q};

`ifdef PREFETCH_BYPASS_EN
  assign bypass_hit = capture & ~stored;
  assign q_valid    = stored | bypass_hit;
  assign q_data     = stored ? rd_data : (bypass_hit ? mem_data : 8'h00);
`else
  assign bypass_hit = 1'b0;
  assign q_valid    = stored;
  assign q_data     = stored ? rd_data : 8'h00;
`endif
  assign q_ip       = head_ip_q;

  assign pop        = q_pop & q_valid;
  assign pop_stored = pop & stored;
  // A bypassed byte that is consumed immediately never enters storage.
  assign wr_en      = capture & ~(bypass_hit & pop);

  always_comb begin
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    pend_d     = 1'b0;
    cs_d       = cs_q;
    fetch_ip_d = fetch_ip_q;
    head_ip_d  = head_ip_q;
    if (flush) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      cs_d       = flush_cs;
      fetch_ip_d = flush_ip;
      head_ip_d  = flush_ip;
    end else begin
      pend_d = issue;
      if (issue)      fetch_ip_d = fetch_ip_q + 16'd1;
      if (wr_en)      wr_ptr_d   = ptr_inc(wr_ptr_q);
      if (pop_stored) rd_ptr_d   = ptr_inc(rd_ptr_q);
      if (pop)        head_ip_d  = head_ip_q + 16'd1;
      case ({wr_en, pop_stored})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      pend_q     <= 1'b0;
      cs_q       <= RESET_CS;
      fetch_ip_q <= RESET_IP;
      head_ip_q  <= RESET_IP;
    end else begin
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      pend_q     <= pend_d;
      cs_q       <= cs_d;
      fetch_ip_q <= fetch_ip_d;
      head_ip_q  <= head_ip_d;
    end
  end

  prefetch_ram #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_ram (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (mem_data),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_prefetch_queue.sv
// tb_prefetch_queue -- self-checking bench for prefetch_queue.
// Every issued fetch pushes {ip, byte, issue cycle} to a scoreboard; the
// head of the scoreboard must appear at q_data/q_ip once its latency has
// elapsed and is popped when the decoder consumes it. Flush and reset
// empty the scoreboard, so stale bytes showing up are caught.
module tb_prefetch_queue;
  import core_pkg::*;

  localparam int DEPTH = 6;
`ifdef PREFETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        bus_grant = 1'b0;
  logic [19:0] mem_addr;
  logic        mem_req;
  logic [7:0]  mem_data = 8'h00;
  logic [7:0]  q_data;
  logic        q_valid;
  logic        q_pop = 1'b0;
  logic [15:0] q_ip;
  logic        flush = 1'b0;
  logic [15:0] flush_cs = 16'h0000;
  logic [15:0] flush_ip = 16'h0000;

  typedef struct {
    logic [15:0] ip;
    logic [7:0]  data;
    int          cyc;
  } ent_t;

  ent_t        sb[$];
  logic [15:0] exp_cs, exp_ip;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  bit          armed = 1'b0;

  prefetch_queue #(.DEPTH(DEPTH)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .bus_grant (bus_grant),
    .mem_addr  (mem_addr),
    .mem_req   (mem_req),
    .mem_data  (mem_data),
    .q_data    (q_data),
    .q_valid   (q_valid),
    .q_pop     (q_pop),
    .q_ip      (q_ip),
    .flush     (flush),
    .flush_cs  (flush_cs),
    .flush_ip  (flush_ip)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] mem_byte(input logic [19:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ {a[19:16], 4'h0};
  endfunction

  function automatic logic [19:0] addr_of(input logic [15:0] cs, input logic [15:0] ip);
    return {cs, 4'h0} + {4'h0, ip};
  endfunction

  // Synchronous memory: data for a fetch issued in cycle N shows up in N+1;
  // otherwise the bus carries junk.
  always @(posedge clock) begin
    if (mem_req) mem_data <= mem_byte(mem_addr);
    else         mem_data <= 8'($urandom);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // One clock cycle: drive inputs, check outputs, then advance the model
  // to what the coming posedge commits.
  task automatic step(input logic g, input logic p, input logic fl,
                      input logic [15:0] fcs, input logic [15:0] fip, input logic rn);
    logic exp_v, exp_req;
    ent_t e;
    @(negedge clock);
    bus_grant = g; q_pop = p; flush = fl; flush_cs = fcs; flush_ip = fip; resetn = rn;
    #1;
    exp_v   = (sb.size() > 0) && (cyc >= sb[0].cyc + LAT);
    exp_req = g & ~fl & (sb.size() < DEPTH);
    if (armed) begin
      check_eq("q_valid", 32'(q_valid), 32'(exp_v));
      check_eq("q_ip", 32'(q_ip), 32'((sb.size() > 0) ? sb[0].ip : exp_ip));
      if (exp_v) check_eq("q_data", 32'(q_data), 32'(sb[0].data));
      if (sb.size() == 0) check_eq("q_data_idle", 32'(q_data), 32'h0);
      check_eq("mem_req", 32'(mem_req), 32'(exp_req));
      check_eq("mem_addr", 32'(mem_addr), 32'(addr_of(exp_cs, exp_ip)));
      if (mem_req && exp_req)
        $display("cyc %0d fetch %05h pop %0b q_valid %0b q_ip %04h", cyc, mem_addr, p, q_valid, q_ip);
    end
    if (!rn) begin
      sb.delete();
      exp_cs = RESET_CS_DEF;
      exp_ip = RESET_IP_DEF;
    end else if (fl) begin
      sb.delete();
      exp_cs = fcs;
      exp_ip = fip;
    end else begin
      if (p && exp_v) void'(sb.pop_front());
      if (exp_req) begin
        e.ip   = exp_ip;
        e.data = mem_byte(addr_of(exp_cs, exp_ip));
        e.cyc  = cyc;
        sb.push_back(e);
        exp_ip = exp_ip + 16'd1;
      end
    end
    cyc++;
  endtask

  initial begin
    exp_cs = RESET_CS_DEF;
    exp_ip = RESET_IP_DEF;
    // Reset, then start checking from the first post-reset cycle.
    step(0, 0, 0, 16'h0, 16'h0, 0);
    step(0, 0, 0, 16'h0, 16'h0, 0);
    armed = 1'b1;
    step(0, 0, 0, 16'h0, 16'h0, 0);
    step(0, 0, 0, 16'h0, 16'h0, 1);

    // Fill: FFFF0..FFFF5 issued, then the queue is full and mem_req drops.
    for (int i = 0; i < 10; i++) step(1, 0, 0, 16'h0, 16'h0, 1);
    // Pop every cycle with the bus granted: sustained streaming.
    for (int i = 0; i < 20; i++) step(1, 1, 0, 16'h0, 16'h0, 1);
    // Flush with a fetch in flight; IP then wraps FFFF -> 0000 in-segment.
    step(1, 0, 1, 16'h1234, 16'hFFFE, 1);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 16'h0, 16'h0, 1);
    // Flush and pop together on a non-empty queue: flush wins.
    step(1, 1, 1, 16'h4000, 16'h0100, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 16'h0, 16'h0, 1);
    // 20-bit address wrap: FFFF:0010 -> 00000.
    step(0, 0, 1, 16'hFFFF, 16'h0010, 1);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 16'h0, 16'h0, 1);
    // Empty-queue latency with a single isolated fetch.
    step(0, 0, 1, 16'h0800, 16'h0000, 1);
    step(1, 0, 0, 16'h0, 16'h0, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 16'h0, 16'h0, 1);

    // Random grant/pop traffic with occasional flushes.
    for (int i = 0; i < 500; i++) begin
      logic fl;
      logic [15:0] fip;
      fl  = ($urandom_range(0, 39) == 0);
      fip = ($urandom_range(0, 3) == 0) ? 16'hFFFD : 16'($urandom);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), fl, 16'($urandom), fip, 1);
    end

    // Reset in the middle of traffic drops the in-flight byte.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 16'h0, 16'h0, 1);
    step(0, 0, 0, 16'h0, 16'h0, 0);
    for (int i = 0; i < 12; i++) step(1, 1'(i[0]), 0, 16'h0, 16'h0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
